// File: rtl/sparse_mac_array.sv
// Sparse MAC array: LANES zero-gated signed multipliers -> adder tree -> group accumulator.
// Result 3 cycles after a group's last beat; a held result (out_valid && !out_ready) freezes every stage.
module sparse_mac_array #(
  parameter int DATA_WID = 16,
  parameter int LANES    = 4,
  parameter int ACC_WID  = 48,
  parameter int CNT_WID  = 16
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_WID-1:0] weight,
  input  logic [LANES*DATA_WID-1:0] pixel,
  input  logic [LANES-1:0]          wgt_state,
  input  logic [LANES-1:0]          ifm_state,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WID-1:0]        psum_out,
  output logic [CNT_WID-1:0]        active_cnt
);
  localparam int PROD_WID = 2 * DATA_WID;
  localparam int SUM_WID  = PROD_WID + $clog2(LANES);
  localparam int POP_WID  = $clog2(LANES + 1);
  localparam int CSUM_WID = ((CNT_WID > POP_WID) ? CNT_WID : POP_WID) + 1;

  logic stall, accept;

  logic [LANES-1:0][DATA_WID-1:0] w_d, w_q, p_d, p_q;
  logic [LANES-1:0]               gate_d, gate_q;
  logic                           s1_vld_d, s1_vld_q, s1_last_d, s1_last_q;

  logic [LANES-1:0][PROD_WID-1:0] prod;
  logic signed [SUM_WID-1:0]      tree_sum, s2_sum_d, s2_sum_q;
  logic [POP_WID-1:0]             pop, s2_pop_d, s2_pop_q;
  logic                           s2_vld_d, s2_vld_q, s2_last_d, s2_last_q;

  logic [ACC_WID-1:0]             acc_d, acc_q, acc_next, psum_d, psum_q;
  logic [CSUM_WID-1:0]            cnt_sum;
  logic [CNT_WID-1:0]             cnt_d, cnt_q, cnt_next, act_d, act_q;
  logic                           out_vld_d, out_vld_q;

  assign stall      = out_vld_q && !out_ready;
  assign in_ready   = !stall && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_vld_q;
  assign psum_out   = psum_q;
  assign active_cnt = act_q;

  // Gated-off lanes keep their old operands so the multiplier inputs do not toggle.
  always_comb begin
    w_d       = w_q;
    p_d       = p_q;
    gate_d    = gate_q;
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    if (!stall) begin
      s1_vld_d = accept;
      if (accept) begin
        gate_d    = wgt_state & ifm_state;
        s1_last_d = in_last;
        for (int i = 0; i < LANES; i++) begin
          if (gate_d[i]) begin
            w_d[i] = weight[i*DATA_WID +: DATA_WID];
            p_d[i] = pixel[i*DATA_WID +: DATA_WID];
          end
        end
      end
    end
  end

  always_comb begin
    prod     = '0;
    tree_sum = '0;
    pop      = '0;
    for (int i = 0; i < LANES; i++) begin
      if (gate_q[i]) prod[i] = PROD_WID'($signed(w_q[i])) * PROD_WID'($signed(p_q[i]));
      tree_sum = tree_sum + SUM_WID'($signed(prod[i]));
      pop      = pop + POP_WID'(gate_q[i]);
    end
  end

  always_comb begin
    s2_sum_d  = s2_sum_q;
    s2_pop_d  = s2_pop_q;
    s2_vld_d  = s2_vld_q;
    s2_last_d = s2_last_q;
    if (!stall) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_sum_d  = tree_sum;
        s2_pop_d  = pop;
        s2_last_d = s1_last_q;
      end
    end
  end

  always_comb begin
    acc_next  = acc_q + ACC_WID'(s2_sum_q);
    cnt_sum   = CSUM_WID'(cnt_q) + CSUM_WID'(s2_pop_q);
    cnt_next  = (|cnt_sum[CSUM_WID-1:CNT_WID]) ? '1 : cnt_sum[CNT_WID-1:0];
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    psum_d    = psum_q;
    act_d     = act_q;
    out_vld_d = out_vld_q;
    if (!stall) begin
      out_vld_d = 1'b0;
      if (s2_vld_q) begin
        if (s2_last_q) begin
          psum_d    = acc_next;
          act_d     = cnt_next;
          out_vld_d = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      w_q       <= '0;
      p_q       <= '0;
      gate_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_sum_q  <= '0;
      s2_pop_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      psum_q    <= '0;
      act_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      w_q       <= w_d;
      p_q       <= p_d;
      gate_q    <= gate_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s2_sum_q  <= s2_sum_d;
      s2_pop_q  <= s2_pop_d;
      s2_vld_q  <= s2_vld_d;
      s2_last_q <= s2_last_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      psum_q    <= psum_d;
      act_q     <= act_d;
      out_vld_q <= out_vld_d;
    end
  end
endmodule
